// File: rtl/acc_job_sched.sv
// acc_job_sched: queues (iters, reads) accumulation jobs, configures ACC with
// one job at a time, gates producer beats to exactly iters*reads per job and
// counts ACC output beats to detect job completion.
module acc_job_sched #(
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int JOB_SLOTS              = 4,
  parameter int LOG_JOB_SLOTS          = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              job_valid,
  input  logic [LOG_MAX_ITERS-1:0]          job_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] job_reads,
  output logic                              job_ready,
  output logic                              acc_configure,
  output logic [LOG_MAX_ITERS-1:0]          acc_num_iters,
  output logic [LOG_MAX_READS_PER_ITER-1:0] acc_num_reads_per_iter,
  input  logic                              up_valid,
  output logic                              up_avail,
  output logic                              acc_valid_in,
  input  logic                              acc_avail_out,
  input  logic                              acc_valid_out,
  output logic                              job_done,
  output logic                              err_zero,
  output logic                              err_spurious,
  output logic                              busy,
  output logic [15:0]                       jobs_done_count
);

  localparam int LI = LOG_MAX_ITERS;
  localparam int LR = LOG_MAX_READS_PER_ITER;
  localparam int LP = LI + LR;
  localparam logic [LOG_JOB_SLOTS:0]   FULL_CNT = (LOG_JOB_SLOTS+1)'(JOB_SLOTS);
  localparam logic [LOG_JOB_SLOTS-1:0] LAST_PTR = LOG_JOB_SLOTS'(JOB_SLOTS-1);

  typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_RUN, S_DONE} state_t;

  state_t                  r_state;
  logic [LI-1:0]           r_q_iters [JOB_SLOTS];
  logic [LR-1:0]           r_q_reads [JOB_SLOTS];
  logic [LOG_JOB_SLOTS-1:0] r_wr_ptr, r_rd_ptr;
  logic [LOG_JOB_SLOTS:0]  r_count;
  logic [LI-1:0]           r_acc_iters;
  logic [LR-1:0]           r_acc_reads;
  logic [LP-1:0]           r_in_rem;
  logic [LR-1:0]           r_out_rem;
  logic                    r_err_zero;
  logic                    r_err_spurious;
  logic [15:0]             r_jobs_done_count;

  logic          w_push, w_pop, w_gate, w_run, w_head_zero;
  logic [LI-1:0] w_head_iters;
  logic [LR-1:0] w_head_reads;
  logic [LP-1:0] w_head_prod;

  // queue handshake and head-of-queue decode
  assign job_ready    = (r_count != FULL_CNT);
  assign w_push       = job_valid & job_ready;
  assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
  assign w_head_iters = r_q_iters[r_rd_ptr];
  assign w_head_reads = r_q_reads[r_rd_ptr];
  assign w_head_prod  = LP'(w_head_iters) * LP'(w_head_reads);
  assign w_head_zero  = (w_head_iters == '0) || (w_head_reads == '0);

  // flow gate: only open in RUN while input beats remain for this job
  assign w_run        = (r_state == S_RUN);
  assign w_gate       = w_run && (r_in_rem != '0);
  assign acc_valid_in = up_valid & w_gate;
  assign up_avail     = acc_avail_out & w_gate;

  assign acc_configure          = (r_state == S_CONFIG);
  assign job_done               = (r_state == S_DONE);
  assign busy                   = (r_state != S_IDLE) || (r_count != '0);
  assign acc_num_iters          = r_acc_iters;
  assign acc_num_reads_per_iter = r_acc_reads;
  assign err_zero               = r_err_zero;
  assign err_spurious           = r_err_spurious;
  assign jobs_done_count        = r_jobs_done_count;

  // job FIFO: storage is not reset, only pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_iters[r_wr_ptr] <= job_iters;
        r_q_reads[r_wr_ptr] <= job_reads;
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // job FSM: pop/latch in IDLE, configure pulse, run with beat counting, done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_acc_iters       <= '0;
      r_acc_reads       <= '0;
      r_in_rem          <= '0;
      r_out_rem         <= '0;
      r_err_zero        <= 1'b0;
      r_err_spurious    <= 1'b0;
      r_jobs_done_count <= '0;
    end else begin
      r_err_zero     <= 1'b0;
      r_err_spurious <= acc_valid_out & ~w_run;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_acc_iters <= w_head_iters;
            r_acc_reads <= w_head_reads;
            r_in_rem    <= w_head_prod;
            r_out_rem   <= w_head_reads;
            if (w_head_zero) r_err_zero <= 1'b1;
            else             r_state    <= S_CONFIG;
          end
        end
        S_CONFIG: r_state <= S_RUN;
        S_RUN: begin
          if (acc_valid_in) r_in_rem <= r_in_rem - 1'b1;
          if (acc_valid_out) begin
            r_out_rem <= r_out_rem - 1'b1;
            if (r_out_rem == LR'(1)) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_jobs_done_count <= r_jobs_done_count + 16'd1;
          r_state           <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
